multi_cycle_hs: RTL and testbench
=================================

Name: multi_cycle_hs

Overview:
- Parametrised next-generation multicycle MIPS-subset core: control FSM, PC, IR, MDR, A/B, ALUOut, 32x32 register file and ALU in one block.
- Memory moves outside the core, behind a req/ack handshake with arbitrary wait states.
- Adds bne, addi, j, illegal-op/misalignment halt, a retired-instruction counter and a configurable reset vector.
- Sits as the CPU top under the SoC wrapper, beside the unified instruction/data memory.

Parameters:
- ADDR_W, 32: width of PC and mem_addr (byte address); PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset, truncated to ADDR_W bits.
- CNT_W, 32: width of the retired counter; counter wraps.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write (sw), 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  byte address, word-aligned; stable while mem_req.
- mem_wdata  out  32  store data; stable while mem_req && mem_we.
- mem_rdata  in  32  read data; sampled in the cycle mem_ack=1.
- mem_ack  in  1  access complete; ignored when mem_req=0.
- pc  out  ADDR_W  current PC register.
- halted  out  1  core stopped in HALT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset values (rst=1 at clk edge):
  - state=FETCH, pc=RESET_PC, IR/MDR/A/B/ALUOut=0, retired=0, halted=0.
  - mem_req=0 and mem_we=0 during the reset cycle.
  - Register file contents are not reset.
  - Reset mid-access drops mem_req the next cycle; memory must tolerate an abandoned request.
- Register file: $0 reads 0 and writes to it are ignored. Write happens on the clock edge, readable next cycle.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: IR<=mem_rdata, pc<=pc+4, go to DECODE. Otherwise stay.
  - Zero-wait (ack in same cycle as req) costs 1 cycle.
- DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2). Dispatch on opcode:
  - 0x00 -> EXEC_R; 0x23/0x2B -> ADDR; 0x04/0x05 -> BRANCH; 0x08 -> EXEC_I; 0x02 -> JUMP.
  - Any other opcode -> HALT.
- EXEC_R:
  - funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - Other funct -> HALT with no write.
  - ALUOut<=result, go to WB_R.
- WB_R: rf[rd]<=ALUOut, retire, go to FETCH.
- EXEC_I: ALUOut<=A+sext(imm), go to WB_I.
- WB_I: rf[rt]<=ALUOut, retire, go to FETCH.
- ADDR: ALUOut<=A+sext(imm).
  - If (A+sext(imm))[1:0]!=0 -> HALT with no memory access.
  - Else lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: req read at ALUOut. On ack: MDR<=mem_rdata, go to WB_MEM.
- WB_MEM: rf[rt]<=MDR, retire, go to FETCH.
- MEM_WR: req write ALUOut/B. On ack: retire, go to FETCH.
- BRANCH:
  - Taken if beq && A==B, or bne && A!=B; then pc<=ALUOut.
  - Retire, go to FETCH.
- JUMP: pc<={pc[ADDR_W-1:28], IR[25:0], 2'b00} (truncated to ADDR_W), retire, go to FETCH.
- HALT:
  - halted=1, mem_req=0, pc frozen (points past the faulting instruction); the faulting instruction does not retire.
  - Exit only by rst.
- Cycle cost with zero-wait memory: R/addi/sw 4, lw 5, beq/bne/j 3. Each wait state adds 1 cycle.
- Arithmetic: add/sub/addi wrap, with no overflow trap.
- retired increments by exactly 1 per completed instruction, wrapping at 2^CNT_W.
- mem_we is asserted only in MEM_WR.
- mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_ack=0.

Test Plan:
- Reset, then zero-wait memory running addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, retired=3, 12 cycles after reset release.
- sw $3,8($0) then lw $4,8($0), with memory acking 3 cycles after req:
  - mem_addr/mem_we/mem_wdata held stable throughout.
  - mem_wdata=12 on the store; $4=12.
  - lw takes 5+3+3 cycles.
- beq $1,$1,+2 at pc=0x10 -> pc=0x1C; bne $1,$1,+2 at 0x10 -> pc=0x14; j 0x40 -> pc=0x100.
- Opcode 0x3F at pc=0x20 -> halted=1 two cycles after its fetch ack, pc=0x24, mem_req stays 0, retired unchanged; lw $5,2($0) -> halt with no request.
- rst asserted while a fetch waits on ack -> next cycle mem_req=0, pc=RESET_PC, retired=0; run RESET_PC=0x400 -> first mem_addr=0x400.
- Write addi $0,$0,9, then add $6,$0,$0 -> $6=0.

Source files
------------

// File: rtl/multi_cycle_hs.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_hs
// Brief    : Multicycle MIPS-subset core (FSM, RF, ALU) with a req/ack memory
//            port, halt on illegal/misaligned ops and a retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_hs #(
    parameter int          ADDR_W   = 32,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] c_RESET_PC = RESET_PC[ADDR_W-1:0];

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_F_ADD = 6'h20;
    localparam logic [5:0] c_F_SUB = 6'h22;
    localparam logic [5:0] c_F_AND = 6'h24;
    localparam logic [5:0] c_F_OR  = 6'h25;
    localparam logic [5:0] c_F_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_WB_MEM = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       mdr_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       alu_q;
    logic [CNT_W-1:0]  retired_q;
    logic              halted_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rf_q [32];

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [31:0]       w_imm_sext;
    logic [31:0]       w_rs_val;
    logic [31:0]       w_rt_val;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [31:0]       w_eff;
    logic [31:0]       w_pc32;
    logic [31:0]       w_jmp32;
    logic [ADDR_W-1:0] w_jmp_pc;
    logic              w_taken;
    logic [ADDR_W-1:0] w_br_pc;
    logic [31:0]       w_r_res;
    logic              w_r_ok;

    assign w_op       = ir_q[31:26];
    assign w_rs       = ir_q[25:21];
    assign w_rt       = ir_q[20:16];
    assign w_rd       = ir_q[15:11];
    assign w_funct    = ir_q[5:0];
    assign w_imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];
    assign w_pc_inc   = pc_q + ADDR_W'(4);
    assign w_br_tgt   = pc_q + ADDR_W'(w_imm_sext << 2);
    assign w_eff      = a_q + w_imm_sext;
    assign w_pc32     = 32'(pc_q);
    assign w_jmp32    = (w_pc32 & 32'hF000_0000) | {4'b0000, ir_q[25:0], 2'b00};
    assign w_jmp_pc   = ADDR_W'(w_jmp32);
    assign w_taken    = (w_op == c_OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
    assign w_br_pc    = w_taken ? ADDR_W'(alu_q) : pc_q;

    always_comb begin
        w_r_res = 32'd0;
        w_r_ok  = 1'b1;
        case (w_funct)
            c_F_ADD: w_r_res = a_q + b_q;
            c_F_SUB: w_r_res = a_q - b_q;
            c_F_AND: w_r_res = a_q & b_q;
            c_F_OR:  w_r_res = a_q | b_q;
            c_F_SLT: w_r_res = {31'd0, ($signed(a_q) < $signed(b_q))};
            default: w_r_ok  = 1'b0;
        endcase
    end

    // The next fetch request is armed on the same edge that retires an
    // instruction, so a zero-wait fetch occupies exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= c_RESET_PC;
            ir_q      <= 32'd0;
            mdr_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_q     <= 32'd0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            req_q     <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= c_RESET_PC;
            wdata_q   <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= w_pc_inc;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= w_rs_val;
                    b_q   <= w_rt_val;
                    alu_q <= 32'(w_br_tgt);
                    case (w_op)
                        c_OP_RTYPE:         state_q <= S_EXEC_R;
                        c_OP_LW, c_OP_SW:   state_q <= S_ADDR;
                        c_OP_BEQ, c_OP_BNE: state_q <= S_BRANCH;
                        c_OP_ADDI:          state_q <= S_EXEC_I;
                        c_OP_J:             state_q <= S_JUMP;
                        default: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    if (w_r_ok) begin
                        alu_q   <= w_r_res;
                        state_q <= S_WB_R;
                    end else begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_WB_R: begin
                    if (w_rd != 5'd0) rf_q[w_rd] <= alu_q;
                    retired_q <= retired_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    addr_q    <= pc_q;
                    state_q   <= S_FETCH;
                end
                S_EXEC_I: begin
                    alu_q   <= w_eff;
                    state_q <= S_WB_I;
                end
                S_WB_I: begin
                    if (w_rt != 5'd0) rf_q[w_rt] <= alu_q;
                    retired_q <= retired_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    addr_q    <= pc_q;
                    state_q   <= S_FETCH;
                end
                S_ADDR: begin
                    alu_q <= w_eff;
                    if (w_eff[1:0] != 2'b00) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= ADDR_W'(w_eff);
                        we_q    <= (w_op == c_OP_SW);
                        wdata_q <= b_q;
                        state_q <= (w_op == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        mdr_q   <= mem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_WB_MEM;
                    end
                end
                S_WB_MEM: begin
                    if (w_rt != 5'd0) rf_q[w_rt] <= mdr_q;
                    retired_q <= retired_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    addr_q    <= pc_q;
                    state_q   <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        we_q      <= 1'b0;
                        retired_q <= retired_q + CNT_W'(1);
                        addr_q    <= pc_q;
                        state_q   <= S_FETCH;
                    end
                end
                S_BRANCH: begin
                    pc_q      <= w_br_pc;
                    retired_q <= retired_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    addr_q    <= w_br_pc;
                    state_q   <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q      <= w_jmp_pc;
                    retired_q <= retired_q + CNT_W'(1);
                    req_q     <= 1'b1;
                    addr_q    <= w_jmp_pc;
                    state_q   <= S_FETCH;
                end
                S_HALT: begin
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                    req_q    <= 1'b0;
                end
            endcase
        end
    end

    // Gating by rst keeps the port quiet for every cycle reset is held.
    assign mem_req   = req_q & ~rst;
    assign mem_we    = we_q & ~rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_hs
// Brief    : Directed and random program bench for multi_cycle_hs with an
//            ISA-level reference model and wait-state memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_hs;

    localparam logic [31:0] c_HALT_WORD = 32'hFC00_0000;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;

    logic        mem_req2, mem_we2, mem_ack2, halted2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2, retired2;

    multi_cycle_hs dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc(pc), .halted(halted), .retired(retired)
    );

    multi_cycle_hs #(.RESET_PC(64'h400)) dut2 (
        .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .mem_ack(mem_ack2), .pc(pc2), .halted(halted2), .retired(retired2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] mem   [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    int          m_ret;
    bit          m_halt;
    logic [31:0] prog [$];

    int          wait_n = 0;
    int          acks   = 0;
    logic [31:0] last_waddr, last_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int tgt_word);
        return {6'h02, 26'(tgt_word)};
    endfunction

    // Memory responder: acks wait_n cycles after a request is first seen,
    // and watches that an outstanding request keeps its attributes.
    initial begin
        int          wcnt = 0;
        logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
        logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (mem_req && p_req && !p_ack) begin
                check("hold_addr", mem_addr, p_addr);
                check("hold_we", mem_we, p_we);
                if (mem_we) check("hold_wdata", mem_wdata, p_wdata);
            end
            if (mem_req) begin
                if (wcnt >= wait_n) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (mem_we) begin
                        mem[mem_addr[11:2]] = mem_wdata;
                        last_waddr = mem_addr;
                        last_wdata = mem_wdata;
                    end
                    acks++;
                    wcnt = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt      = 0;
            end
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
            p_addr = mem_addr; p_wdata = mem_wdata;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_mem();
        for (int i = 0; i < 1024; i++) begin
            if (i < prog.size())  mem[i] = prog[i];
            else if (i < 512)     mem[i] = c_HALT_WORD;
            else                  mem[i] = $urandom;
            m_mem[i] = mem[i];
        end
        for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
    endtask

    // Leaves rst asserted just after a reset edge; release() drops it.
    task automatic hold_reset(input int w);
        rst = 1'b1;
        wait_n = w;
        repeat (2) @(posedge clk);
        load_mem();
        acks = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
    endtask

    task automatic run_until(input string tag, input int tgt, input bit to_halt,
                             input int bound, output int cyc);
        bit done = 1'b0;
        cyc = 0;
        while (cyc < bound && !done) begin
            @(posedge clk);
            #1;
            cyc++;
            done = to_halt ? (halted === 1'b1) : (retired === 32'(tgt));
        end
        check({"reach_", tag}, done, 1'b1);
    endtask

    // Instruction-level reference: executes the program and totals cycle cost.
    task automatic model_run(input int w, output int cyc);
        logic [31:0] ins, a, b, res, se;
        int op, fn, rs, rt, rd;
        bit taken;
        m_pc = 32'd0; m_ret = 0; m_halt = 1'b0; cyc = 0;
        for (int s = 0; s < 1000 && !m_halt; s++) begin
            ins  = m_mem[m_pc[11:2]];
            m_pc = m_pc + 32'd4;
            op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
            rd = int'(ins[15:11]); fn = int'(ins[5:0]);
            se = {{16{ins[15]}}, ins[15:0]};
            a  = (rs == 0) ? 32'd0 : m_reg[rs];
            b  = (rt == 0) ? 32'd0 : m_reg[rt];
            case (op)
                'h00: begin
                    case (fn)
                        'h20: res = a + b;
                        'h22: res = a - b;
                        'h24: res = a & b;
                        'h25: res = a | b;
                        'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: m_halt = 1'b1;
                    endcase
                    if (m_halt) cyc += 3 + w;
                    else begin
                        if (rd != 0) m_reg[rd] = res;
                        m_ret++; cyc += 4 + w;
                    end
                end
                'h08: begin
                    if (rt != 0) m_reg[rt] = a + se;
                    m_ret++; cyc += 4 + w;
                end
                'h23, 'h2B: begin
                    res = a + se;
                    if (res[1:0] != 2'b00) begin
                        m_halt = 1'b1; cyc += 3 + w;
                    end else if (op == 'h23) begin
                        if (rt != 0) m_reg[rt] = m_mem[res[11:2]];
                        m_ret++; cyc += 5 + 2 * w;
                    end else begin
                        m_mem[res[11:2]] = b;
                        m_ret++; cyc += 4 + 2 * w;
                    end
                end
                'h04, 'h05: begin
                    taken = (op == 'h04) ? (a == b) : (a != b);
                    if (taken) m_pc = m_pc + (se << 2);
                    m_ret++; cyc += 3 + w;
                end
                'h02: begin
                    m_pc = {m_pc[31:28], ins[25:0], 2'b00};
                    m_ret++; cyc += 3 + w;
                end
                default: begin
                    m_halt = 1'b1; cyc += 2 + w;
                end
            endcase
        end
    endtask

    task automatic gen_random();
        int fns [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
        prog.delete();
        for (int r = 1; r < 8; r++) prog.push_back(enc_i('h08, 0, r, int'($urandom_range(0, 65535))));
        for (int i = 0; i < 24; i++) begin
            int k  = int'($urandom_range(0, 9));
            int rs = int'($urandom_range(0, 7));
            int rt = int'($urandom_range(0, 7));
            int rd = int'($urandom_range(0, 7));
            int ofs = 'h800 + 4 * int'($urandom_range(0, 63));
            case (k)
                0, 1, 2: prog.push_back(enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]));
                3:       prog.push_back(enc_i('h08, rs, rt, int'($urandom_range(0, 65535))));
                4:       prog.push_back(enc_i('h23, 0, rt, ofs));
                5:       prog.push_back(enc_i('h2B, 0, rt, ofs));
                6:       prog.push_back(enc_i('h04, rs, rt, int'($urandom_range(0, 3))));
                7:       prog.push_back(enc_i('h05, rs, rt, int'($urandom_range(0, 3))));
                8:       prog.push_back(enc_j(prog.size() + 1 + int'($urandom_range(0, 3))));
                default: prog.push_back(enc_r(rs, rt, rd, int'($urandom_range(0, 63))));
            endcase
        end
    endtask

    task automatic random_run(input int w);
        int exp_cyc, cyc;
        gen_random();
        hold_reset(w);
        model_run(w, exp_cyc);
        release_rst();
        run_until("rnd_halt", 0, 1'b1, 3000, cyc);
        check("rnd_cycles", cyc, exp_cyc);
        check("rnd_pc", pc, m_pc);
        check("rnd_retired", retired, m_ret);
        for (int r = 1; r < 8; r++) check("rnd_reg", dut.rf_q[r], m_reg[r]);
        for (int i = 512; i < 576; i++) check("rnd_mem", mem[i], m_mem[i]);
    endtask

    initial begin
        int cyc, c0;
        rst = 1'b1;
        mem_ack2 = 1'b0;
        mem_rdata2 = 32'd0;

        // Three ALU instructions, zero-wait memory.
        prog = '{enc_i('h08, 0, 1, 5), enc_i('h08, 0, 2, 7), enc_r(1, 2, 3, 'h20)};
        hold_reset(0);
        check("rst_pc", pc, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        release_rst();
        run_until("alu3", 3, 1'b0, 100, cyc);
        check("alu3_cycles", cyc, 12);
        check("alu3_r3", dut.rf_q[3], 32'd12);
        check("alu3_pc", pc, 32'h0C);
        run_until("alu3_halt", 0, 1'b1, 100, cyc);
        check("alu3_halt_pc", pc, 32'h10);
        check("alu3_halt_ret", retired, 32'd3);

        // Store then load with three wait states per access.
        prog = '{enc_i('h08, 0, 1, 5), enc_i('h08, 0, 2, 7), enc_r(1, 2, 3, 'h20),
                 enc_i('h2B, 0, 3, 8), enc_i('h23, 0, 4, 8)};
        hold_reset(3);
        release_rst();
        run_until("sw", 4, 1'b0, 200, cyc);
        check("sw_waddr", last_waddr, 32'd8);
        check("sw_wdata", last_wdata, 32'd12);
        run_until("lw", 5, 1'b0, 100, cyc);
        check("lw_cycles", cyc, 11);
        check("lw_r4", dut.rf_q[4], 32'd12);

        // beq taken, then jump.
        prog = '{enc_i('h08, 0, 1, 3), enc_r(0, 0, 0, 'h20), enc_r(0, 0, 0, 'h20),
                 enc_r(0, 0, 0, 'h20), enc_i('h04, 1, 1, 2), enc_r(0, 0, 0, 'h20),
                 enc_r(0, 0, 0, 'h20), enc_j('h40)};
        hold_reset(0);
        release_rst();
        run_until("beq", 5, 1'b0, 100, cyc);
        check("beq_pc", pc, 32'h1C);
        run_until("j", 6, 1'b0, 100, cyc);
        check("j_pc", pc, 32'h100);

        // bne not taken.
        prog[4] = enc_i('h05, 1, 1, 2);
        hold_reset(1);
        release_rst();
        run_until("bne", 5, 1'b0, 100, cyc);
        check("bne_pc", pc, 32'h14);

        // Illegal opcode at 0x20.
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(enc_r(0, 0, 0, 'h20));
        prog.push_back(32'hFC00_0000);
        hold_reset(0);
        release_rst();
        run_until("ill_pre", 8, 1'b0, 100, cyc);
        run_until("ill_halt", 0, 1'b1, 20, cyc);
        check("ill_cycles", cyc, 2);
        check("ill_pc", pc, 32'h24);
        check("ill_ret", retired, 32'd8);
        c0 = acks;
        repeat (4) begin
            @(posedge clk); #1;
            check("ill_noreq", mem_req, 1'b0);
        end
        check("ill_acks", acks, c0);

        // Misaligned load halts before any data access.
        prog = '{enc_i('h23, 0, 5, 2)};
        hold_reset(0);
        release_rst();
        run_until("mis", 0, 1'b1, 20, cyc);
        check("mis_cycles", cyc, 3);
        check("mis_pc", pc, 32'h4);
        check("mis_ret", retired, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mis_acks", acks, 1);
        check("mis_noreq", mem_req, 1'b0);

        // Unknown funct halts without writing rd.
        prog = '{enc_i('h08, 0, 7, 1), enc_r(1, 1, 7, 'h00)};
        hold_reset(0);
        release_rst();
        run_until("fn", 0, 1'b1, 50, cyc);
        check("fn_r7", dut.rf_q[7], 32'd1);
        check("fn_ret", retired, 32'd1);

        // $0 stays zero.
        prog = '{enc_i('h08, 0, 6, 3), enc_i('h08, 0, 0, 9), enc_r(0, 0, 6, 'h20)};
        hold_reset(0);
        release_rst();
        run_until("r0", 3, 1'b0, 100, cyc);
        check("r0_r6", dut.rf_q[6], 32'd0);

        // Reset while a fetch waits on ack.
        prog = '{enc_i('h08, 0, 1, 5), enc_i('h08, 0, 2, 7)};
        hold_reset(5);
        release_rst();
        run_until("mid", 1, 1'b0, 100, cyc);
        repeat (2) @(posedge clk);
        #1;
        check("mid_req_before", mem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_req", mem_req, 1'b0);
        check("mid_pc", pc, 32'd0);
        check("mid_ret", retired, 32'd0);
        check("mid_halted", halted, 1'b0);
        check("vec_req_rst", mem_req2, 1'b0);
        release_rst();
        #1;
        check("vec_req", mem_req2, 1'b1);
        check("vec_addr", mem_addr2, 32'h400);
        check("vec_pc", pc2, 32'h400);
        check("vec_we", mem_we2, 1'b0);

        // Random programs at several wait-state settings.
        random_run(0);
        random_run(1);
        random_run(2);
        random_run(3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
